key_debounce_scan: RTL and testbench
====================================

Name: key_debounce_scan

Overview:
- Input-side companion to the board's active-low 4-bit LED driver.
- Samples four active-low push-buttons, synchronises and debounces each one, and emits clean level, press-pulse and release-pulse outputs.
- Also emits an encoded key event (code + valid strobe) that downstream control logic uses, e.g. to change running-light direction or speed.
- Sits directly behind the board key pins, one instance per key bank.

Parameters:
- KEY_NUM, 4, number of keys handled; fixed at 4 for this block.
- CNT_W, 20, debounce counter width.
- DEBOUNCE_COUNT, 20'd1_000_000, stable cycles required before a key change is accepted (20 ms at 50 MHz); benches override to 4.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- key_in  input  4  raw key pins, active-low (0 = pressed), asynchronous to sys_clk.
- key_state  output  4  debounced level, 1 = pressed.
- key_press  output  4  one-cycle pulse per key on accepted press.
- key_release  output  4  one-cycle pulse per key on accepted release.
- key_code  output  2  index of the most recent accepted press.
- key_valid  output  1  one-cycle strobe qualifying key_code.

Behaviour:
- Clock and reset: one clock, sys_clk. sys_rst_n is asynchronous and active-low.
- Reset values:
  - key_state, key_press, key_release, key_code and key_valid are all 0.
  - Both synchroniser stages reset to 1 (released), so no false press follows reset.
  - Every per-key FSM resets to IDLE with its counter at 0.
- Synchroniser: 2-flop chain per key, giving key_sync. Logic uses only key_sync, never key_in.
- Per-key FSM, N = DEBOUNCE_COUNT:
  - IDLE: if key_sync = 0 (pressed), go to PRESS_FILT with cnt = 0.
  - PRESS_FILT:
    - key_sync = 1 returns to IDLE with cnt = 0; the bounce is discarded.
    - Otherwise cnt increments.
    - When cnt = N-1 and the key is still pressed, go to DOWN, set key_state = 1 and pulse key_press for one cycle.
  - DOWN: if key_sync = 1, go to REL_FILT with cnt = 0.
  - REL_FILT:
    - key_sync = 0 returns to DOWN.
    - When cnt = N-1 and the key is still released, go to IDLE, set key_state = 0 and pulse key_release for one cycle.
- Latency: for key_in stable from the sampling edge t0, key_press and key_state change after edge t0+N+2. Release timing is symmetric.
- Counter rules:
  - cnt never exceeds N-1 and does not wrap.
  - Counter width must hold N-1; an illegal N (0 or ≥ 2^CNT_W) is unsupported.
- Encoder:
  - key_valid and key_code are registered one cycle after any key_press bit is set.
  - On simultaneous presses, the lowest index wins; exactly one key_valid strobe is emitted.
  - key_code holds its last value when key_valid = 0.
- Independence: each key is handled independently. A press on one key never affects another key's FSM or counter.
- Reset mid-operation: asynchronous return to reset values. Any partial filter progress is lost, and a full N-cycle filter is needed after reset release.
- Glitches: pulses shorter than N cycles in any filter state produce no output change and no pulse.

Decomposition:
- Shared package key_pkg holds:
  - FSM state encodings: IDLE, PRESS_FILT, DOWN, REL_FILT as 2-bit constants.
  - KEY_NUM.
  - Default DEBOUNCE_COUNT.
- Sub-module key_debounce_one: synchroniser, FSM and counter for a single key. It is instantiated KEY_NUM times.
- Top level adds the priority encoder and its key_code/key_valid registers.

Test Plan (DEBOUNCE_COUNT = 4):
- Reset: hold sys_rst_n = 0 with key_in = 4'hF, then release and idle 50 cycles -> all outputs 0 throughout, no pulses.
- Clean press: key_in = 4'b1101 from edge t0 -> key_press = 4'b0010 for one cycle after edge t0+6, key_state[1] = 1, then key_valid = 1 with key_code = 2'd1 after edge t0+7.
- Bounce: toggle key_in[0] every 2 cycles for 20 cycles, then hold low -> exactly one key_press[0] pulse, 6 cycles after the final falling edge; no key_release.
- Simultaneous: key_in = 4'b1010 at one edge -> key_press = 4'b0101 in the same cycle, one key_valid with key_code = 2'd0, key_state = 4'b0101.
- Release and glitch:
  - A 2-cycle high glitch on a held key -> no key_release.
  - key_in back to 4'hF -> key_release pulse 6 cycles later and key_state returns to 0.
- Reset mid-filter: assert sys_rst_n = 0 during PRESS_FILT -> outputs immediately 0. After release, the key still held gives key_press only after the full latency counted from reset release.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the key debounce block.
//   key_fsm_e          : per-key debounce FSM states (2-bit)
//   KEY_NUM            : number of keys per bank
//   KEY_CODE_W         : width of the encoded key index
//   DEBOUNCE_COUNT_DEF : default stable-cycle count (20 ms at 50 MHz)
package key_pkg;

  localparam int unsigned KEY_NUM            = 4;
  localparam int unsigned KEY_CODE_W         = 2;
  localparam int unsigned DEBOUNCE_COUNT_DEF = 1_000_000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_fsm_e;

endpackage

// File: rtl/key_debounce_one.sv
// Single-key debouncer: two-flop synchroniser followed by a press/release filter FSM.
//   sys_clk     : system clock, rising edge
//   sys_rst_n   : asynchronous active-low reset
//   key_in      : raw key pin, active-low, asynchronous to sys_clk
//   key_state   : debounced level, 1 = pressed
//   key_press   : one-cycle pulse when a press is accepted
//   key_release : one-cycle pulse when a release is accepted
module key_debounce_one
  import key_pkg::*;
#(
  parameter int unsigned CNT_W          = 20,
  parameter int unsigned DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_COUNT - 1);

  logic [1:0]       sync_q;
  logic             key_sync;
  key_fsm_e         state_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchroniser resets to "released" so no false press follows reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_in};
    end
  end

  assign key_sync = sync_q[1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!key_sync) begin
            state_q <= PRESS_FILT;
            cnt_q   <= '0;
          end
        end
        PRESS_FILT: begin
          if (key_sync) begin
            // Bounce: discard progress and wait for a fresh press.
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q   <= DOWN;
            cnt_q     <= '0;
            key_state <= 1'b1;
            key_press <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DOWN: begin
          if (key_sync) begin
            state_q <= REL_FILT;
            cnt_q   <= '0;
          end
        end
        REL_FILT: begin
          if (!key_sync) begin
            state_q <= DOWN;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_state   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_scan.sv
// Four-key debounce bank with a priority key-event encoder.
//   sys_clk     : system clock, rising edge
//   sys_rst_n   : asynchronous active-low reset
//   key_in      : raw key pins, active-low
//   key_state   : debounced levels, 1 = pressed
//   key_press   : per-key one-cycle press pulses
//   key_release : per-key one-cycle release pulses
//   key_code    : index of the most recent accepted press (lowest index wins on ties)
//   key_valid   : one-cycle strobe qualifying key_code
module key_debounce_scan
  import key_pkg::*;
#(
  parameter int unsigned CNT_W          = 20,
  parameter int unsigned DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [KEY_NUM-1:0]    key_in,
  output logic [KEY_NUM-1:0]    key_state,
  output logic [KEY_NUM-1:0]    key_press,
  output logic [KEY_NUM-1:0]    key_release,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid
);

  logic [KEY_CODE_W-1:0] enc_code;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    key_debounce_one #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_COUNT (DEBOUNCE_COUNT)
    ) u_key (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key_in      (key_in[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

  // Scan from the top down so the lowest pressed index is the last assignment.
  always_comb begin
    enc_code = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (key_press[i]) begin
        enc_code = KEY_CODE_W'(i);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= |key_press;
      if (|key_press) begin
        key_code <= enc_code;
      end
    end
  end

endmodule

// File: tb/tb_key_debounce_scan.sv
module tb_key_debounce_scan;

  localparam int N = 4;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] key_in;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [1:0] key_code;
  logic       key_valid;

  key_debounce_scan #(
    .CNT_W          (20),
    .DEBOUNCE_COUNT (N)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_code    (key_code),
    .key_valid   (key_valid)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int fails  = 0;
  int npress0;

  // Reference model: a key's accepted level flips once the synchronised pin
  // has disagreed with it on N+1 consecutive clock edges.
  logic [3:0] pin_hist[$];
  logic [3:0] m_state, m_press, m_rel, m_prev_press;
  logic [1:0] m_code;
  logic       m_valid;
  int         m_run[4];

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pin_hist     = '{4'hF, 4'hF};
    m_state      = '0;
    m_press      = '0;
    m_rel        = '0;
    m_prev_press = '0;
    m_code       = '0;
    m_valid      = 1'b0;
    for (int k = 0; k < 4; k++) m_run[k] = 0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".key_state"},   key_state,   m_state);
    chk({ph, ".key_press"},   key_press,   m_press);
    chk({ph, ".key_release"}, key_release, m_rel);
    chk({ph, ".key_valid"},   {3'b0, key_valid}, {3'b0, m_valid});
    chk({ph, ".key_code"},    {2'b0, key_code},  {2'b0, m_code});
  endtask

  // One clock edge: advance the model with the pins sampled two edges ago, then compare.
  task automatic step(input string ph);
    logic [3:0] seen;
    @(posedge sys_clk);
    seen = pin_hist[0];
    m_valid = |m_prev_press;
    if (m_valid) begin
      for (int k = 3; k >= 0; k--) if (m_prev_press[k]) m_code = 2'(k);
    end
    m_press = '0;
    m_rel   = '0;
    for (int k = 0; k < 4; k++) begin
      if (!seen[k] != m_state[k]) begin
        m_run[k]++;
        if (m_run[k] == N + 1) begin
          m_state[k] = ~m_state[k];
          m_run[k]   = 0;
          if (m_state[k]) m_press[k] = 1'b1;
          else            m_rel[k]   = 1'b1;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_prev_press = m_press;
    pin_hist.push_back(key_in);
    void'(pin_hist.pop_front());
    #1;
    if (key_press[0]) npress0++;
    check_all(ph);
  endtask

  int hold;

  initial begin
    // Reset held with keys released.
    sys_rst_n = 1'b0;
    key_in    = 4'hF;
    model_reset();
    repeat (3) begin
      @(posedge sys_clk);
      #1;
      check_all("reset");
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (50) step("idle");

    // Clean press of key 1.
    key_in = 4'b1101;
    repeat (6) step("clean");
    chk("clean.no_early_press", key_press, 4'b0000);
    step("clean");
    chk("clean.press_t6", key_press, 4'b0010);
    chk("clean.state_t6", key_state, 4'b0010);
    step("clean");
    chk("clean.valid_t7", {3'b0, key_valid}, 4'h1);
    chk("clean.code_t7", {2'b0, key_code}, 4'h1);
    key_in = 4'hF;
    repeat (20) step("clean_rel");

    // Bounce on key 0, then hold low.
    npress0 = 0;
    for (int i = 0; i < 10; i++) begin
      key_in[0] = ~key_in[0];
      repeat (2) step("bounce");
    end
    key_in[0] = 1'b0;
    repeat (6) step("bounce_hold");
    chk("bounce.no_press_during", {3'b0, npress0 != 0}, 4'h0);
    step("bounce_hold");
    chk("bounce.press_t6", key_press, 4'b0001);
    repeat (10) step("bounce_hold");
    chk("bounce.one_pulse", npress0[3:0], 4'h1);
    key_in = 4'hF;
    repeat (20) step("bounce_rel");

    // Simultaneous press of keys 0 and 2.
    key_in = 4'b1010;
    repeat (7) step("simul");
    chk("simul.press", key_press, 4'b0101);
    step("simul");
    chk("simul.valid", {3'b0, key_valid}, 4'h1);
    chk("simul.code", {2'b0, key_code}, 4'h0);
    chk("simul.state", key_state, 4'b0101);
    step("simul");
    chk("simul.single_strobe", {3'b0, key_valid}, 4'h0);
    repeat (5) step("simul");

    // Short release glitch on key 2 while held, then full release.
    key_in = 4'b1110;
    repeat (2) step("glitch");
    key_in = 4'b1010;
    repeat (10) step("glitch");
    chk("glitch.state_held", key_state, 4'b0101);
    key_in = 4'hF;
    repeat (7) step("release");
    chk("release.pulse_t6", key_release, 4'b0101);
    chk("release.state", key_state, 4'b0000);
    repeat (10) step("release");

    // Reset while key 0 is mid-filter.
    key_in = 4'b1110;
    repeat (4) step("midrst");
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst.async");
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (6) step("midrst");
    chk("midrst.no_early_press", key_press, 4'b0000);
    step("midrst");
    chk("midrst.press_full", key_press, 4'b0001);
    repeat (5) step("midrst");

    // Randomised pin activity: random patterns held for random short runs.
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        key_in = 4'($urandom);
        hold   = int'($urandom_range(1, 9));
      end
      hold--;
      step("random");
    end
    key_in = 4'hF;
    repeat (12) step("final");
    chk("final.state", key_state, 4'b0000);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
